// File: rtl/move_ctl.sv
// MIX MOVE sequencer: copies len words src->dst ascending via a shared memory req/gnt port.
// Latency: 3*len+2 cycles start-to-done with immediate grant; each grant stall adds one cycle.
// Backpressure: requests are held stable until mem_gnt; start is ignored while busy.
// Optional range check (abort with err instead of wrapping): define MOVE_RANGE_CHECK_EN.
module move_ctl #(
    parameter int AW        = 12,
    parameter int DW        = 31,
    parameter int LW        = 6,
    parameter int MEM_WORDS = 4000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] ri1_out,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, FIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] src_q, dst_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] k;
    logic [LW-1:0] k_inc;
    logic [DW-1:0] buf_q;
    logic [AW-1:0] src_k, dst_k;
    logic          abort_start;
    logic          abort_next;

    assign k_inc = k + LW'(1);
    assign src_k = src_q + AW'(k);
    assign dst_k = dst_q + AW'(k);

`ifdef MOVE_RANGE_CHECK_EN
    logic abort_q;

    // Address a+off falls outside the populated memory (evaluated one bit wider so it cannot wrap).
    function automatic logic out_of_range(input logic [AW-1:0] a, input logic [LW-1:0] off);
        return ({1'b0, a} + (AW+1)'(off)) >= (AW+1)'(MEM_WORDS);
    endfunction

    // Checked before a word's RD; its WR uses the same k, so no separate check is needed there.
    assign abort_start = out_of_range(src, '0) | out_of_range(dst, '0);
    assign abort_next  = out_of_range(src_q, k_inc) | out_of_range(dst_q, k_inc);
`else
    assign abort_start = 1'b0;
    assign abort_next  = 1'b0;
    assign err         = 1'b0;
`endif

    // Next-state and memory-port drive; port outputs follow the state so reset drops mem_req at once.
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = buf_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0 || abort_start) state_nx = FIN;
                    else                          state_nx = RD;
                end
            end
            RD: begin
                mem_req  = 1'b1;
                mem_addr = src_k;
                if (mem_gnt) state_nx = RWAIT;
            end
            RWAIT: state_nx = WR;
            WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_k;
                if (mem_gnt) begin
                    if (k_inc == len_q || abort_next) state_nx = FIN;
                    else                              state_nx = RD;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, operand latches, word counter, data buffer and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            k       <= '0;
            buf_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ri1_out <= '0;
`ifdef MOVE_RANGE_CHECK_EN
            err     <= 1'b0;
            abort_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src;
                        dst_q <= dst;
                        len_q <= len;
                        k     <= '0;
                        busy  <= 1'b1;
`ifdef MOVE_RANGE_CHECK_EN
                        err     <= 1'b0;
                        abort_q <= (len != '0) && abort_start;
`endif
                    end
                end
                RWAIT: buf_q <= mem_rdata;
                WR: begin
                    if (mem_gnt) begin
                        k <= k_inc;
`ifdef MOVE_RANGE_CHECK_EN
                        abort_q <= (k_inc != len_q) && abort_next;
`endif
                    end
                end
                FIN: begin
                    // k equals the number of words fully copied, which is len on a clean finish.
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    ri1_out <= dst_q + AW'(k);
`ifdef MOVE_RANGE_CHECK_EN
                    err     <= abort_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/move_ctl.md
Name: move_ctl

Overview:
- Sequencer for the MIX MOVE instruction (C=7).
- Copies `len` words from source address `src` to destination `dst` (the rI1 value) in ascending order, one word at a time.
- Accesses the single shared main memory through a request/grant port; the memory arbiter sits outside this block.
- On completion, reports the updated rI1 value (`dst+len`) to the register file.

Parameters:
- AW, 12, memory address width.
- DW, 31, MIX word width (sign + 5×6-bit bytes).
- LW, 6, length field width (F, 0..63).
- MEM_WORDS, 4000, number of valid memory locations (0..MEM_WORDS-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches src, dst and len.
- src  in  AW  source base address (M).
- dst  in  AW  destination base address (rI1).
- len  in  LW  word count (F).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion or abort.
- err  out  1  high together with done when the move aborted; held until the next start.
- ri1_out  out  AW  final destination pointer; valid when done is high.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  AW  access address.
- mem_wdata  out  DW  write data.
- mem_gnt  in  1  arbiter grant; the access completes on a clock edge where mem_req and mem_gnt are both high.
- mem_rdata  in  DW  read data, valid exactly 1 cycle after the granted read edge.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - busy, done, err, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, ri1_out, internal counter k = 0.
  - Reset asserted mid-move: mem_req drops immediately and no further writes occur. A partially written destination is acceptable.
- States: IDLE, RD, RWAIT, WR, FIN.
- IDLE:
  - start=1 latches src, dst and len; sets k=0; sets busy=1 on the next edge.
  - If len==0: go to FIN; no memory access; ri1_out=dst.
  - Otherwise go to RD.
- RD:
  - Drive mem_req=1, mem_we=0, mem_addr=src+k.
  - Hold all three until mem_gnt; then go to RWAIT.
- RWAIT:
  - mem_req=0.
  - Capture mem_rdata into the data buffer at the end of this cycle; go to WR.
- WR:
  - Drive mem_req=1, mem_we=1, mem_addr=dst+k, mem_wdata=buffer.
  - Hold until mem_gnt; then k=k+1.
  - If k+1==len go to FIN, else go to RD.
- FIN:
  - done=1 for one cycle; busy=0 on that edge.
  - ri1_out = dst+len, truncated to AW.
  - Go to IDLE.
- Grant behaviour:
  - mem_gnt is ignored while mem_req=0.
  - Requests are never withdrawn before grant.
  - Minimum per-word cost with immediate grant is 3 cycles; total = 3·len + 2 cycles from start to done.
- start while busy is ignored; the latched operands are unchanged.
- Address arithmetic is AW-bit; see the optional feature for range handling.
- Overlapping ranges are copied strictly word-by-word in ascending order, as MIX semantics require. If dst = src+1, the same word is replicated.

Optional Feature:
- Macro: MOVE_RANGE_CHECK_EN.
- With the macro defined:
  - Before each RD or WR request is issued, if src+k ≥ MEM_WORDS or dst+k ≥ MEM_WORDS (computed in AW+1 bits), no request is made.
  - The block goes to FIN with err=1.
  - ri1_out = dst+k, i.e. the number of words fully copied.
- Without the macro:
  - Addresses wrap modulo 2^AW.
  - err is tied to 0.

Test Plan:
- M[100]=12345, M[101]=1245, src=100, dst=200, len=2, gnt tied 1 -> M[200]=12345, M[201]=1245; done at cycle 8 after start; ri1_out=202; err=0.
- len=0, src=100, dst=300 -> no mem_req ever; done 2 cycles after start; ri1_out=300; memory unchanged.
- len=10, gnt withheld 3 cycles on every request -> mem_addr, mem_we and mem_wdata stable while waiting; all 10 words copied correctly; total cycles = 10·(3+6)+2.
- M[50]=7, src=50, dst=51, len=3 -> M[51]=M[52]=M[53]=7 (ascending overlap replication).
- Second start pulse during busy with different operands -> ignored; first move completes unchanged. rst_n low during the 2nd word's WR -> mem_req=0 immediately; busy=0; only 1 destination word written.
- With MOVE_RANGE_CHECK_EN: src=3998, dst=10, len=5 -> 2 words copied; done with err=1; ri1_out=12; no request to address 4000.
